// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus bundle: peripheral requests, CPU register port,
// control-unit decode strobes and dispatch sequencing outputs.
// The controller side uses the slave modport; the CPU/testbench side uses master.
interface interrupt_controller_if #(
  parameter int NUM_IRQ = 5
);
  logic               i_Enable;
  logic [NUM_IRQ-1:0] i_Irq;
  logic               i_Reg_Write;
  logic               i_Reg_Sel;
  logic [7:0]         i_Reg_Wdata;
  logic [7:0]         o_IF;
  logic [7:0]         o_IE;
  logic               i_EI;
  logic               i_DI;
  logic               i_RETI;
  logic               i_Instr_Boundary;
  logic               o_Handle_Interrupt;
  logic               o_Dispatch_Active;
  logic [2:0]         o_Dispatch_Step;
  logic [15:0]        o_Vector;
  logic               o_Wake;
  logic               o_IME;

  modport master (
    output i_Enable, i_Irq, i_Reg_Write, i_Reg_Sel, i_Reg_Wdata,
    output i_EI, i_DI, i_RETI, i_Instr_Boundary,
    input  o_IF, o_IE, o_Handle_Interrupt, o_Dispatch_Active,
    input  o_Dispatch_Step, o_Vector, o_Wake, o_IME
  );

  modport slave (
    input  i_Enable, i_Irq, i_Reg_Write, i_Reg_Sel, i_Reg_Wdata,
    input  i_EI, i_DI, i_RETI, i_Instr_Boundary,
    output o_IF, o_IE, o_Handle_Interrupt, o_Dispatch_Active,
    output o_Dispatch_Step, o_Vector, o_Wake, o_IME
  );
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt controller: IF/IE registers, IME with EI delay, fixed-priority
// arbitration (bit 0 highest) and the 5 M-cycle dispatch sequence.
// Optional macro INTERRUPT_CANCEL_EN: when nothing is pending at the step-3
// resolve, the vector becomes 16'h0000 instead of the entry snapshot.
module interrupt_controller #(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter int          VECTOR_STRIDE = 8
) (
  input logic                  i_Clk,
  input logic                  i_Reset,
  interrupt_controller_if.slave bus
);
  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic {IDLE, DISPATCH} state_t;

  state_t             state_reg, state_next;
  logic [2:0]         step_reg, step_next;
  logic [1:0]         tcnt_reg, tcnt_next;
  logic [NUM_IRQ-1:0] if_reg;
  logic [NUM_IRQ-1:0] if_next;
  logic [7:0]         ie_reg;
  logic               ime_reg;
  logic               ime_pend_reg;
  logic [15:0]        vector_reg;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [IDX_W-1:0]   low_idx;
  logic               low_found;
  logic [15:0]        resolved_vec;
  logic               ime_eff;
  logic               handle;
  logic               resolve;
  logic               if_write;

  assign pending      = if_reg & ie_reg[NUM_IRQ-1:0];
  assign resolved_vec = VECTOR_BASE + 16'(VECTOR_STRIDE) * 16'(low_idx);
  // A pending EI promotion counts at the boundary where it takes effect.
  assign ime_eff      = (ime_reg | (ime_pend_reg & bus.i_Instr_Boundary)) & ~bus.i_DI;
  assign if_write     = bus.i_Reg_Write & ~bus.i_Reg_Sel;

  // Lowest set pending bit wins (bit 0 highest priority).
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx   = IDX_W'(i);
        low_found = 1'b1;
      end
    end
  end

  // Dispatch clear targets only the resolved source.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_clr
    assign clr_mask[gi] = resolve & low_found & (low_idx == IDX_W'(gi));
  end

  // IF next value: write or dispatch clear, then peripheral pulses OR'd on top.
  always_comb begin
    if_next = if_reg | bus.i_Irq;
    if (bus.i_Enable) begin
      if_next = (if_write ? bus.i_Reg_Wdata[NUM_IRQ-1:0] : (if_reg & ~clr_mask)) | bus.i_Irq;
    end
  end

  // FSM next-state: entry at a boundary, then 5 steps of 4 enabled T-cycles.
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    tcnt_next  = tcnt_reg;
    handle     = 1'b0;
    resolve    = 1'b0;
    if (bus.i_Enable) begin
      case (state_reg)
        IDLE: begin
          if (ime_eff && (|pending) && bus.i_Instr_Boundary) begin
            handle     = 1'b1;
            state_next = DISPATCH;
            step_next  = 3'd0;
            tcnt_next  = 2'd0;
          end
        end
        DISPATCH: begin
          resolve   = (step_reg == 3'd3) && (tcnt_reg == 2'd0);
          tcnt_next = tcnt_reg + 2'd1;
          if (tcnt_reg == 2'd3) begin
            if (step_reg == 3'd4) begin
              state_next = IDLE;
              step_next  = 3'd0;
            end else begin
              step_next = step_reg + 3'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          step_next  = 3'd0;
          tcnt_next  = 2'd0;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg <= IDLE;
      step_reg  <= 3'd0;
      tcnt_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      tcnt_reg  <= tcnt_next;
    end
  end

  // Registers: IF captures pulses every clock; everything else only when enabled.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      if_reg       <= '0;
      ie_reg       <= 8'h00;
      ime_reg      <= 1'b0;
      ime_pend_reg <= 1'b0;
      vector_reg   <= 16'h0000;
    end else begin
      if_reg <= if_next;
      if (bus.i_Enable) begin
        if (bus.i_Reg_Write && bus.i_Reg_Sel) begin
          ie_reg <= bus.i_Reg_Wdata;
        end
        if (bus.i_DI || handle) begin
          ime_reg      <= 1'b0;
          ime_pend_reg <= 1'b0;
        end else begin
          if (ime_pend_reg && bus.i_Instr_Boundary) begin
            ime_reg      <= 1'b1;
            ime_pend_reg <= 1'b0;
          end
          if (bus.i_RETI) begin
            ime_reg <= 1'b1;
          end
          if (bus.i_EI) begin
            ime_pend_reg <= 1'b1;
          end
        end
        if (resolve) begin
          if (low_found) begin
            vector_reg <= resolved_vec;
          end else begin
`ifdef INTERRUPT_CANCEL_EN
            vector_reg <= 16'h0000;
`else
            vector_reg <= vector_reg;
`endif
          end
        end else if (handle) begin
`ifdef INTERRUPT_CANCEL_EN
          vector_reg <= vector_reg;
`else
          vector_reg <= resolved_vec;
`endif
        end
      end
    end
  end

  assign bus.o_IF               = {{(8 - NUM_IRQ){1'b1}}, if_reg};
  assign bus.o_IE               = ie_reg;
  assign bus.o_Wake             = |pending;
  assign bus.o_IME              = ime_reg;
  assign bus.o_Handle_Interrupt = handle;
  assign bus.o_Dispatch_Active  = (state_reg == DISPATCH);
  assign bus.o_Dispatch_Step    = step_reg;
  assign bus.o_Vector           = vector_reg;
endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller: directed scenarios with a
// vector scoreboard (expected vectors queued at dispatch entry, compared at step 4).
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  interrupt_controller_if #(.NUM_IRQ(5)) bus ();

  interrupt_controller #(
    .NUM_IRQ(5),
    .VECTOR_BASE(16'h0040),
    .VECTOR_STRIDE(8)
  ) dut (
    .i_Clk(clk),
    .i_Reset(rst),
    .bus(bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  bit          rand_en  = 1'b0;
  int          en_cnt   = 0;
  bit          prev_active = 1'b0;
  bit          vec_seen = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and dispatch-length monitor, sampled mid-cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    if (rst) begin
      en_cnt      = 0;
      prev_active = 1'b0;
      vec_seen    = 1'b0;
    end else begin
      if (prev_active && !bus.o_Dispatch_Active) begin
        check_eq("dispatch_len", 32'(en_cnt), 32'd20);
        en_cnt   = 0;
        vec_seen = 1'b0;
      end
      if (bus.o_Dispatch_Active && bus.o_Dispatch_Step == 3'd4 && !vec_seen) begin
        vec_seen = 1'b1;
        if (exp_q.size() == 0) begin
          check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          $display("txn dispatch vector=%h expected=%h", bus.o_Vector, e);
          check_eq("vector", 32'(bus.o_Vector), 32'(e));
        end
      end
      if (bus.i_Enable && bus.o_Dispatch_Active) en_cnt++;
      prev_active = bus.o_Dispatch_Active;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.i_Enable = 1'b1; bus.i_Irq = '0; bus.i_Reg_Write = 1'b0; bus.i_Reg_Sel = 1'b0;
    bus.i_Reg_Wdata = 8'h00; bus.i_EI = 1'b0; bus.i_DI = 1'b0; bus.i_RETI = 1'b0;
    bus.i_Instr_Boundary = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic write_reg(input logic sel, input logic [7:0] data);
    bus.i_Reg_Write = 1'b1; bus.i_Reg_Sel = sel; bus.i_Reg_Wdata = data;
    tick();
    bus.i_Reg_Write = 1'b0;
  endtask

  task automatic pulse_irq(input logic [4:0] mask);
    bus.i_Irq = mask;
    tick();
    bus.i_Irq = '0;
  endtask

  task automatic pulse_reti();
    bus.i_RETI = 1'b1;
    tick();
    bus.i_RETI = 1'b0;
  endtask

  // Raise a boundary expecting dispatch entry; queue the vector if one will be produced.
  task automatic boundary_dispatch(input string tag, input bit push, input logic [15:0] vec);
    bus.i_Instr_Boundary = 1'b1;
    #1;
    check_eq(tag, 32'(bus.o_Handle_Interrupt), 32'd1);
    if (push) exp_q.push_back(vec);
    tick();
    bus.i_Instr_Boundary = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (bus.o_Dispatch_Active !== 1'b0 && n < budget) begin
      if (rand_en) bus.i_Enable = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    bus.i_Enable = 1'b1;
    check_eq("dispatch_ended", 32'(bus.o_Dispatch_Active), 32'd0);
  endtask

  task automatic wait_step(input logic [2:0] s, input int budget);
    int n = 0;
    while (bus.o_Dispatch_Step !== s && n < budget) begin
      tick();
      n++;
    end
    check_eq("reach_step", 32'(bus.o_Dispatch_Step), 32'(s));
  endtask

  initial begin
    do_reset();
    // Reset state
    check_eq("rst_if", 32'(bus.o_IF), 32'hE0);
    check_eq("rst_ie", 32'(bus.o_IE), 32'h00);
    check_eq("rst_ime", 32'(bus.o_IME), 32'd0);
    check_eq("rst_active", 32'(bus.o_Dispatch_Active), 32'd0);
    check_eq("rst_step", 32'(bus.o_Dispatch_Step), 32'd0);
    check_eq("rst_vector", 32'(bus.o_Vector), 32'h0);
    check_eq("rst_wake", 32'(bus.o_Wake), 32'd0);
    check_eq("rst_handle", 32'(bus.o_Handle_Interrupt), 32'd0);

    // EI delay
    write_reg(1'b1, 8'h01);
    pulse_irq(5'h01);
    check_eq("ei_wake", 32'(bus.o_Wake), 32'd1);
    check_eq("ei_if", 32'(bus.o_IF), 32'hE1);
    bus.i_EI = 1'b1; bus.i_Instr_Boundary = 1'b1;
    #1;
    check_eq("ei_no_dispatch_A", 32'(bus.o_Handle_Interrupt), 32'd0);
    tick();
    bus.i_EI = 1'b0; bus.i_Instr_Boundary = 1'b0;
    check_eq("ei_ime_still_0", 32'(bus.o_IME), 32'd0);
    tick(); tick(); tick();
    boundary_dispatch("ei_handle_B", 1'b1, 16'h0040);
    check_eq("ei_ime_after_B", 32'(bus.o_IME), 32'd0);
    check_eq("ei_active", 32'(bus.o_Dispatch_Active), 32'd1);
    check_eq("ei_step0", 32'(bus.o_Dispatch_Step), 32'd0);
    wait_done(200);
    check_eq("ei_if_cleared", 32'(bus.o_IF), 32'hE0);

    // Priority, then second dispatch after RETI with a gappy enable
    do_reset();
    write_reg(1'b1, 8'h1F);
    pulse_reti();
    check_eq("prio_ime", 32'(bus.o_IME), 32'd1);
    pulse_irq(5'h14);
    check_eq("prio_if_14", 32'(bus.o_IF), 32'hF4);
    boundary_dispatch("prio_handle1", 1'b1, 16'h0050);
    wait_done(200);
    check_eq("prio_if_10", 32'(bus.o_IF), 32'hF0);
    bus.i_Instr_Boundary = 1'b1;
    #1;
    check_eq("prio_no_dispatch_ime0", 32'(bus.o_Handle_Interrupt), 32'd0);
    tick();
    bus.i_Instr_Boundary = 1'b0;
    pulse_reti();
    rand_en = 1'b1;
    boundary_dispatch("prio_handle2", 1'b1, 16'h0060);
    wait_done(400);
    rand_en = 1'b0;
    check_eq("prio_if_empty", 32'(bus.o_IF), 32'hE0);

    // Late higher-priority request during step 1
    do_reset();
    write_reg(1'b1, 8'h1F);
    pulse_reti();
    pulse_irq(5'h08);
    boundary_dispatch("late_handle", 1'b1, 16'h0048);
    wait_step(3'd1, 50);
    pulse_irq(5'h02);
    wait_done(200);
    check_eq("late_if3_kept", 32'(bus.o_IF), 32'hE8);

    // Collision: IF write of 00 with a same-clock pulse on bit 1
    pulse_irq(5'h01);
    check_eq("coll_pre", 32'(bus.o_IF), 32'hE9);
    bus.i_Irq = 5'h02;
    write_reg(1'b0, 8'h00);
    bus.i_Irq = '0;
    check_eq("coll_if", 32'(bus.o_IF), 32'hE2);
    // Disabled clock: writes ignored, pulses still captured
    bus.i_Enable = 1'b0;
    bus.i_Irq = 5'h10;
    write_reg(1'b1, 8'hAA);
    bus.i_Irq = '0;
    bus.i_Enable = 1'b1;
    check_eq("noen_ie", 32'(bus.o_IE), 32'h1F);
    check_eq("noen_if", 32'(bus.o_IF), 32'hF2);

    // HALT wake without IME
    do_reset();
    write_reg(1'b1, 8'h04);
    pulse_irq(5'h04);
    check_eq("halt_wake", 32'(bus.o_Wake), 32'd1);
    bus.i_Instr_Boundary = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("halt_no_handle", 32'(bus.o_Handle_Interrupt), 32'd0);
      tick();
    end
    bus.i_Instr_Boundary = 1'b0;
    check_eq("halt_idle", 32'(bus.o_Dispatch_Active), 32'd0);

    // EI and DI together: DI wins, nothing left pending
    do_reset();
    bus.i_EI = 1'b1; bus.i_DI = 1'b1;
    tick();
    bus.i_EI = 1'b0; bus.i_DI = 1'b0;
    check_eq("eidi_ime", 32'(bus.o_IME), 32'd0);
    for (int i = 0; i < 2; i++) begin
      bus.i_Instr_Boundary = 1'b1; tick();
      bus.i_Instr_Boundary = 1'b0; tick();
    end
    check_eq("eidi_ime_later", 32'(bus.o_IME), 32'd0);

    // Reset mid-dispatch
    write_reg(1'b1, 8'h01);
    pulse_reti();
    pulse_irq(5'h01);
    boundary_dispatch("rst_mid_handle", 1'b0, 16'h0000);
    wait_step(3'd2, 50);
    rst = 1'b1;
    tick();
    check_eq("rstmid_active", 32'(bus.o_Dispatch_Active), 32'd0);
    check_eq("rstmid_if", 32'(bus.o_IF), 32'hE0);
    check_eq("rstmid_ie", 32'(bus.o_IE), 32'h00);
    check_eq("rstmid_ime", 32'(bus.o_IME), 32'd0);
    check_eq("rstmid_vector", 32'(bus.o_Vector), 32'h0);
    rst = 1'b0;
    tick(); tick();

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Owns the IF and IE interrupt registers, the IME master enable and the EI delay.
- Arbitrates the five interrupt sources by fixed priority.
- Sequences the 5 M-cycle interrupt dispatch for the CPU control unit.
- Sits beside the control unit: raises o_Handle_Interrupt at instruction boundaries, steps the dispatch micro-sequence and supplies the vector. The control unit drives the bus/register lines from o_Dispatch_Step.

Parameters:
- NUM_IRQ, 5, number of interrupt sources; bit 0 has the highest priority.
- VECTOR_BASE, 16'h0040, vector of source 0.
- VECTOR_STRIDE, 8, address gap between consecutive vectors.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Enable  in  1  T-cycle advance qualifier, same as the control unit's clock enable.
- i_Irq  in  NUM_IRQ  one-clock request pulses from peripherals; each sets the matching IF bit.
- i_Reg_Write  in  1  CPU register write strobe.
- i_Reg_Sel  in  1  0 = IF (FF0F), 1 = IE (FFFF).
- i_Reg_Wdata  in  8  write data.
- o_IF  out  8  IF readback; bits above NUM_IRQ read 1.
- o_IE  out  8  IE readback; full 8 bits stored.
- i_EI, i_DI, i_RETI  in  1 each  one-clock decode strobes from the control unit.
- i_Instr_Boundary  in  1  last T-cycle of an opcode (end of fetch).
- o_Handle_Interrupt  out  1  dispatch requested at this boundary.
- o_Dispatch_Active  out  1  dispatch sequence running.
- o_Dispatch_Step  out  3  current dispatch M-cycle, 0..4.
- o_Vector  out  16  target PC; valid from step 3 onward.
- o_Wake  out  1  |(IF & IE), independent of IME; used for HALT exit.
- o_IME  out  1  master enable state.

Behaviour:
- Reset values:
  - IF = 0, IE = 0, IME = 0, ime_pend = 0.
  - State = IDLE.
  - All outputs 0, except o_IF upper bits, which read 1.
- All state updates occur on posedge i_Clk only when i_Enable = 1. The exceptions are i_Reset and i_Irq capture, which happen every clock, so pulses are never lost.
- IF update:
  - IF_next = (write ? wdata : IF_after_clear) | i_Irq.
  - A peripheral pulse always wins over a register write or a dispatch clear of the same bit in the same clock.
- IE update: plain 8-bit register write.
- pending = IF & IE[NUM_IRQ-1:0]. o_Wake = |pending, combinational.
- EI delay:
  - i_EI sets ime_pend.
  - At the next i_Instr_Boundary after the one carrying i_EI, IME <= 1 and ime_pend <= 0.
- i_DI clears IME and ime_pend immediately; it overrides i_EI in the same clock.
- i_RETI sets IME immediately, with no delay.
- IDLE:
  - If IME = 1, |pending, and i_Instr_Boundary: go to DISPATCH.
  - On entry: o_Handle_Interrupt = 1 for that clock, IME <= 0, ime_pend <= 0, M-cycle counter = 0.
- DISPATCH: the step advances every 4 enabled clocks (one M-cycle).
  - Steps 0 and 1: wait cycles, PC decrement.
  - Step 2: push PC high byte.
  - Step 3, first T-cycle: resolve the lowest set bit of pending and latch o_Vector = VECTOR_BASE + VECTOR_STRIDE*n. Clear IF[n], unless i_Irq[n] is high in the same clock. Then push PC low byte.
  - Step 4: PC <= o_Vector.
  - At the end of step 4: o_Dispatch_Active <= 0, return to IDLE.
- o_Dispatch_Active is high for exactly 20 enabled clocks.
- Re-evaluation: priority is resolved at step 3, not at entry. A higher-priority request arriving during steps 0-2 takes the vector.
- Register writes during dispatch are honoured with the normal rules.
- Reset mid-dispatch: returns to IDLE within the same clock with all registers cleared; no vector is produced.

Optional Feature:
- Macro: INTERRUPT_CANCEL_EN.
- Defined: if pending = 0 when the vector is resolved at step 3, o_Vector = 16'h0000, no IF bit is cleared, and the dispatch still completes. This models an IE overwrite by the high-byte push.
- Not defined: the vector latched at dispatch entry is used. Resolution still happens at step 3, but falls back to the entry snapshot when pending = 0.

Test Plan:
- EI delay: IE = 01, IME = 0, pulse i_Irq[0], then i_EI at boundary A → no o_Handle_Interrupt at A; it asserts at the next boundary B, o_IME falls at B, and o_Vector = 16'h0040 at step 3.
- Priority: IME = 1, IE = 1F, pulse i_Irq[2] and i_Irq[4] together → vector 16'h0050; IF goes 14 → 10; a second dispatch follows after RETI with vector 16'h0060.
- Late higher priority: dispatch started for bit 3; pulse i_Irq[1] during step 1 → o_Vector = 16'h0048; IF[3] remains set.
- Collision: i_Reg_Write IF = 00 in the same clock as i_Irq[1] → o_IF = 8'hE2.
- HALT wake: IME = 0, IE = 04, i_Irq[2] pulse → o_Wake = 1 the next clock; o_Handle_Interrupt never asserts.
- DI and reset: i_EI and i_DI in the same clock → IME stays 0. i_Reset asserted at step 2 → next clock o_Dispatch_Active = 0, IF = 0, IE = 0.
